// File: rtl/dataplane_pkg.sv
// dataplane_pkg: shared protocol constants, flow key layout and parser state encoding.
package dataplane_pkg;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETHERTYPE_VLAN = 16'h8100;
    localparam logic [7:0] IP_PROTO_TCP = 8'd6;
    localparam logic [7:0] IP_PROTO_UDP = 8'd17;
    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [23:0] rsvd;
        logic [7:0] proto;
    } flow_key_t;
    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_SKIP} parse_state_t;
endpackage

// File: rtl/flow_key_extract_if.sv
// flow_key_extract_if: 64-bit AXI-Stream frame bus; the parser only observes it.
interface flow_key_extract_if;
    logic [63:0] tdata;
    logic [7:0] tkeep;
    logic tvalid;
    logic tready;
    logic tlast;
    modport master (output tdata, tkeep, tvalid, tready, tlast);
    modport slave (input tdata, tkeep, tvalid, tready, tlast);
endinterface

// File: rtl/flow_key_extract_sat_counter.sv
// sat_counter: synchronous increment counter that sticks at all-ones.
module sat_counter #(parameter int W = 16) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;
    assign cnt_d = (inc && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
    assign cnt = cnt_q;
endmodule

// File: rtl/flow_key_extract.sv
// flow_key_extract: taps an AXI-Stream Ethernet bus and emits the IPv4 5-tuple key of each eligible frame.
// Define FLOW_KEY_VLAN_EN to accept one 802.1Q tag ahead of the IPv4 header.
module flow_key_extract
    import dataplane_pkg::*;
#(parameter int CNT_W = 16) (
    input  logic clk,
    input  logic rst,
    flow_key_extract_if.slave s_axis,
    output flow_key_t flow_key,
    output logic flow_key_valid,
    output logic [CNT_W-1:0] cnt_keys,
    output logic [CNT_W-1:0] cnt_skipped,
    output logic [CNT_W-1:0] cnt_runt
);
    parse_state_t state_q, state_d;
    logic [2:0] beat_q, beat_d, beat, done_beat, off;
    logic inel_q, inel_d, valid_q, valid_d;
    logic fire, keep_bad, bad, ipv4_ok1, tag_q;
    logic inc_keys, inc_skip, inc_runt;
    logic [15:0] eth1;
    logic [7:0] need;
    logic [5:0] n;
    logic [127:0] acc_q, acc_d;
    flow_key_t key_q, key_d, emit_key;
    assign fire = s_axis.tvalid && s_axis.tready;
    assign beat = (state_q == ST_IDLE) ? 3'd0 : beat_q;
    assign eth1 = {s_axis.tdata[39:32], s_axis.tdata[47:40]};
    assign ipv4_ok1 = eth1 == ETHERTYPE_IPV4 && s_axis.tdata[55:48] == 8'h45;
`ifdef FLOW_KEY_VLAN_EN
    logic tag_d;
    logic [15:0] eth2;
    assign eth2 = {s_axis.tdata[7:0], s_axis.tdata[15:8]};
    always_comb begin
        tag_d = tag_q;
        if (fire && state_q == ST_IDLE) tag_d = 1'b0;
        else if (fire && state_q == ST_HDR && beat_q == 3'd1) tag_d = eth1 == ETHERTYPE_VLAN;
    end
    always_ff @(posedge clk) tag_q <= rst ? 1'b0 : tag_d;
    // a tagged frame reveals its inner ethertype one beat later; a second tag fails here
    assign bad = (beat == 3'd1 && !ipv4_ok1 && eth1 != ETHERTYPE_VLAN) ||
                 (tag_q && beat == 3'd2 && !(eth2 == ETHERTYPE_IPV4 && s_axis.tdata[23:16] == 8'h45));
`else
    assign tag_q = 1'b0;
    assign bad = beat == 3'd1 && !ipv4_ok1;
`endif
    assign off = tag_q ? 3'd4 : 3'd0;
    assign done_beat = tag_q ? 3'd5 : 3'd4;
    assign need = (beat != done_beat) ? 8'hFF : tag_q ? 8'h03 : 8'h3F;
    assign keep_bad = (s_axis.tkeep & need) != need;
    // key bits 127..32 are frame bytes 26..37 (after the tag shift) in wire order
    always_comb begin
        acc_d = acc_q;
        n = '0;
        for (int j = 0; j < 8; j++) begin
            n = {beat, 3'(j)} - 6'(off);
            if (fire && state_q != ST_SKIP && n == 6'd23) acc_d[7:0] = s_axis.tdata[8*j +: 8];
            if (fire && state_q != ST_SKIP && n >= 6'd26 && n <= 6'd37) acc_d[127 - 8*(n - 6'd26) -: 8] = s_axis.tdata[8*j +: 8];
        end
    end
    always_comb begin
        emit_key = acc_d;
        emit_key.rsvd = '0;
        if (emit_key.proto != IP_PROTO_TCP && emit_key.proto != IP_PROTO_UDP) begin
            emit_key.src_port = '0;
            emit_key.dst_port = '0;
        end
    end
    always_comb begin
        state_d = state_q;
        beat_d = beat_q;
        inel_d = inel_q;
        key_d = key_q;
        valid_d = 1'b0;
        inc_keys = 1'b0;
        inc_skip = 1'b0;
        inc_runt = 1'b0;
        if (fire) begin
            if (state_q == ST_SKIP) begin
                state_d = s_axis.tlast ? ST_IDLE : ST_SKIP;
                inc_skip = s_axis.tlast && inel_q;
            end else if (keep_bad) begin
                inc_runt = 1'b1;
                inel_d = 1'b0;
                state_d = s_axis.tlast ? ST_IDLE : ST_SKIP;
            end else if (bad) begin
                inc_skip = s_axis.tlast;
                inel_d = 1'b1;
                state_d = s_axis.tlast ? ST_IDLE : ST_SKIP;
            end else if (beat == done_beat) begin
                key_d = emit_key;
                valid_d = 1'b1;
                inc_keys = 1'b1;
                inel_d = 1'b0;
                state_d = s_axis.tlast ? ST_IDLE : ST_SKIP;
            end else if (s_axis.tlast) begin
                inc_runt = 1'b1;
                state_d = ST_IDLE;
            end else begin
                state_d = ST_HDR;
                beat_d = beat + 3'd1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q <= '0;
            inel_q <= 1'b0;
            acc_q <= '0;
            key_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q <= beat_d;
            inel_q <= inel_d;
            acc_q <= acc_d;
            key_q <= key_d;
            valid_q <= valid_d;
        end
    end
    assign flow_key = key_q;
    assign flow_key_valid = valid_q;
    sat_counter #(.W(CNT_W)) u_cnt_keys (.clk(clk), .rst(rst), .inc(inc_keys), .cnt(cnt_keys));
    sat_counter #(.W(CNT_W)) u_cnt_skipped (.clk(clk), .rst(rst), .inc(inc_skip), .cnt(cnt_skipped));
    sat_counter #(.W(CNT_W)) u_cnt_runt (.clk(clk), .rst(rst), .inc(inc_runt), .cnt(cnt_runt));
endmodule

// File: doc/flow_key_extract.md
# flow_key_extract

Passive header parser that sits directly upstream of the flow table lookup stage. It taps a 64-bit AXI-Stream Ethernet frame bus and extracts the IPv4 5-tuple of each eligible frame into a 128-bit flow key. For each eligible frame it pulses `flow_key_valid` for one cycle, which drives the flow table's key/valid inputs. It keeps saturating statistics for emitted, skipped and truncated frames.

## Interface
- `CNT_W`, default 16: width of each statistics counter.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `s_axis_tdata` in 64: frame data; byte n of a beat is in `[8n+7:8n]`, first wire byte in byte 0.
- `s_axis_tkeep` in 8: byte valid qualifiers.
- `s_axis_tvalid` in 1: beat valid.
- `s_axis_tready` in 1: observed only; a beat is accepted when `tvalid && tready`.
- `s_axis_tlast` in 1: last beat of frame.
- `flow_key` out 128: extracted key; holds its value between emissions.
- `flow_key_valid` out 1: one-cycle pulse qualifying `flow_key`.
- `cnt_keys` out CNT_W: keys emitted.
- `cnt_skipped` out CNT_W: complete frames that are not eligible.
- `cnt_runt` out CNT_W: frames that end, or lack `tkeep`, before the last needed byte.

## Operation
- Frame byte offsets (untagged):
  - ethertype at bytes 12-13
  - IPv4 version/IHL at byte 14
  - protocol at byte 23
  - source IP at bytes 26-29
  - destination IP at bytes 30-33
  - L4 ports at bytes 34-37
- Key layout: `[127:96]` src IP, `[95:64]` dst IP, `[63:48]` src port, `[47:32]` dst port, `[31:8]` zero, `[7:0]` protocol. Each multi-byte field is big-endian, so the lower wire byte is more significant.
- Eligibility rules:
  - ethertype must be 0x0800, version 4 and IHL 5; otherwise the frame is counted as skipped.
  - Protocols 6 (TCP) and 17 (UDP) take ports from the frame.
  - Any other protocol emits the key with both port fields zero.
- State machine:
  - IDLE: the next accepted beat is beat 0 of a frame; go to HDR with beat count 1.
  - HDR: capture fields while the beat counter (3 bits) advances.
    - Eligibility failure decided at beat 1 or 2: go to SKIP.
    - `tlast` or a cleared needed `tkeep` bit before the completing beat: increment `cnt_runt`, go to IDLE (or SKIP if `tlast` not yet seen).
    - Completing beat accepted: emit, then go to SKIP, or to IDLE if that beat has `tlast`.
  - SKIP: discard beats until `tlast` is accepted, then go to IDLE. `cnt_skipped` increments at the `tlast` of an ineligible frame.
- Cycles without an accepted beat do not advance any state.
- A single-beat frame (`tlast` on beat 0) counts as runt.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset values: `flow_key` = 0, `flow_key_valid` = 0, all counters 0, state IDLE.
- The next accepted beat after `rst` deasserts is treated as beat 0.
- The completing beat is beat 4 (bytes 32-39) untagged, or beat 5 when tagged.
- `flow_key` and `flow_key_valid` are registered and update 1 cycle after the completing beat is accepted. `flow_key_valid` is high for exactly 1 cycle.
- Back-to-back minimum frames (5 beats, no gaps) give one pulse every 5 cycles. There is no backpressure; this block never stalls the bus.
- Counter increments are visible 1 cycle after the deciding beat.
- `rst` asserted mid-frame aborts the frame with no counter update.

## Configuration
- `FLOW_KEY_VLAN_EN` defined:
  - ethertype 0x8100 at bytes 12-13 is accepted as one 802.1Q tag.
  - The inner ethertype moves to bytes 16-17 and all IP/L4 offsets shift by +4 (ports at bytes 38-41).
  - Tagged frames complete at beat 5.
  - A second tag (0x8100 again) counts as skipped.
- Undefined: 0x8100 frames count as skipped. No tag logic is generated and untagged behaviour is identical.

## Structure
- The following go in `dataplane_pkg`:
  - constants `ETHERTYPE_IPV4` and `ETHERTYPE_VLAN`
  - constants `IP_PROTO_TCP` and `IP_PROTO_UDP`
  - a packed `flow_key_t` struct matching the key layout
  - the parser state enum
- One sub-module, `sat_counter` (parameter width, synchronous increment, sync active-high reset), is instantiated three times.

## Test plan
- Untagged UDP frame, src 10.0.0.1, dst 10.0.0.2, ports 1234→80, 8 beats, no gaps.
  - One pulse 1 cycle after beat 4.
  - `flow_key` = 0x0A000001_0A000002_04D2_0050_000000_11.
  - `cnt_keys` = 1.
- Same frame with `tvalid` gaps and `tready` low on random cycles → identical key; pulse 1 cycle after beat 4 is accepted.
- Frames with ethertype 0x86DD, and IPv4 with IHL 6 → no pulse; `cnt_skipped` = 2.
- IPv4 frame with `tlast` on beat 3 → no pulse; `cnt_runt` = 1; the next valid frame is parsed correctly.
- ICMP (protocol 1) frame → key with `[63:32]` = 0 and `[7:0]` = 0x01.
- With `FLOW_KEY_VLAN_EN`, VLAN-tagged TCP frame → pulse 1 cycle after beat 5 with correct key; without the macro → `cnt_skipped` increments.
